// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
// Hours/minutes/seconds/hundredths countdown timer. One clk cycle is one
// hundredth of a second. Four states: IDLE, RUNNING, PAUSED, EXPIRED.
//
// Ports
//   clk           in   system clock (100 cycles per second)
//   reset         in   synchronous active-high reset
//   start         in   run/pause request; only a 0->1 transition counts
//   load          in   preset request (level) from load_* inputs
//   load_hours    in   [5:0] preset hours 0..63
//   load_minutes  in   [5:0] preset minutes, values above 59 clamp to 59
//   load_seconds  in   [5:0] preset seconds, values above 59 clamp to 59
//   hours         out  [5:0] remaining hours (registered)
//   minutes       out  [5:0] remaining minutes (registered)
//   seconds       out  [5:0] remaining seconds (registered)
//   milliseconds  out  [6:0] remaining hundredths 0..99 (registered)
//   running       out  high while RUNNING (registered)
//   done          out  high while EXPIRED (registered)
// ----------------------------------------------------------------------------
module countdown_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       load,
   input  logic [5:0] load_hours,
   input  logic [5:0] load_minutes,
   input  logic [5:0] load_seconds,
   output logic [5:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [6:0] milliseconds,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] hours_q, hours_d;
   logic [5:0] minutes_q, minutes_d;
   logic [5:0] seconds_q, seconds_d;
   logic [6:0] ms_q, ms_d;
   logic       running_q, running_d;
   logic       done_q, done_d;
   logic       start_prev_q;

   logic       start_edge_s;
   logic       time_zero_s;
   logic [5:0] clamp_minutes_s;
   logic [5:0] clamp_seconds_s;
   logic [5:0] dec_hours_s;
   logic [5:0] dec_minutes_s;
   logic [5:0] dec_seconds_s;
   logic [6:0] dec_ms_s;
   logic       dec_zero_s;

   assign start_edge_s    = start & ~start_prev_q;
   assign time_zero_s     = (hours_q == 6'd0) && (minutes_q == 6'd0) &&
                            (seconds_q == 6'd0) && (ms_q == 7'd0);
   assign clamp_minutes_s = (load_minutes > 6'd59) ? 6'd59 : load_minutes;
   assign clamp_seconds_s = (load_seconds > 6'd59) ? 6'd59 : load_seconds;

   // Time minus one hundredth with the borrow chain; only used on nonzero time.
   always_comb begin
      dec_hours_s   = hours_q;
      dec_minutes_s = minutes_q;
      dec_seconds_s = seconds_q;
      dec_ms_s      = ms_q;
      if (ms_q != 7'd0) begin
         dec_ms_s = ms_q - 7'd1;
      end else begin
         dec_ms_s = 7'd99;
         if (seconds_q != 6'd0) begin
            dec_seconds_s = seconds_q - 6'd1;
         end else begin
            dec_seconds_s = 6'd59;
            if (minutes_q != 6'd0) begin
               dec_minutes_s = minutes_q - 6'd1;
            end else begin
               dec_minutes_s = 6'd59;
               dec_hours_s   = hours_q - 6'd1;
            end
         end
      end
   end

   assign dec_zero_s = (dec_hours_s == 6'd0) && (dec_minutes_s == 6'd0) &&
                       (dec_seconds_s == 6'd0) && (dec_ms_s == 7'd0);

   // Next-state, next-time and next-output logic.
   always_comb begin
      state_d   = state_q;
      hours_d   = hours_q;
      minutes_d = minutes_q;
      seconds_d = seconds_q;
      ms_d      = ms_q;
      case (state_q)
         ST_IDLE: begin
            // Load beats a coincident start edge.
            if (load) begin
               hours_d   = load_hours;
               minutes_d = clamp_minutes_s;
               seconds_d = clamp_seconds_s;
               ms_d      = 7'd0;
            end else if (start_edge_s && !time_zero_s) begin
               state_d = ST_RUNNING;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUNNING: begin
            // Start edge pauses without consuming a hundredth; load is ignored.
            if (start_edge_s) begin
               state_d = ST_PAUSED;
            end else if (time_zero_s) begin
               state_d = ST_EXPIRED;
            end else begin
               hours_d   = dec_hours_s;
               minutes_d = dec_minutes_s;
               seconds_d = dec_seconds_s;
               ms_d      = dec_ms_s;
               if (dec_zero_s) begin
                  state_d = ST_EXPIRED;
               end else begin
                  state_d = ST_RUNNING;
               end
            end
         end
         ST_PAUSED: begin
            if (load) begin
               hours_d   = load_hours;
               minutes_d = clamp_minutes_s;
               seconds_d = clamp_seconds_s;
               ms_d      = 7'd0;
               state_d   = ST_IDLE;
            end else if (start_edge_s && !time_zero_s) begin
               state_d = ST_RUNNING;
            end else begin
               state_d = ST_PAUSED;
            end
         end
         ST_EXPIRED: begin
            // Start edges are ignored here; only load leaves EXPIRED.
            if (load) begin
               hours_d   = load_hours;
               minutes_d = clamp_minutes_s;
               seconds_d = clamp_seconds_s;
               ms_d      = 7'd0;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_EXPIRED;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            hours_d   = 6'd0;
            minutes_d = 6'd0;
            seconds_d = 6'd0;
            ms_d      = 7'd0;
         end
      endcase
      // Status flags follow the next state so they stay aligned with the time.
      running_d = (state_d == ST_RUNNING);
      done_d    = (state_d == ST_EXPIRED);
   end

   // State, time, status and start-history registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hours_q      <= 6'd0;
         minutes_q    <= 6'd0;
         seconds_q    <= 6'd0;
         ms_q         <= 7'd0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hours_q      <= hours_d;
         minutes_q    <= minutes_d;
         seconds_q    <= seconds_d;
         ms_q         <= ms_d;
         running_q    <= running_d;
         done_q       <= done_d;
         start_prev_q <= start;
      end
   end

   assign hours        = hours_q;
   assign minutes      = minutes_q;
   assign seconds      = seconds_q;
   assign milliseconds = ms_q;
   assign running      = running_q;
   assign done         = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       load = 1'b0;
   logic [5:0] load_hours = 6'd0;
   logic [5:0] load_minutes = 6'd0;
   logic [5:0] load_seconds = 6'd0;
   logic [5:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [6:0] milliseconds;
   logic       running;
   logic       done;

   int vectors = 0;
   int miscompares = 0;

   countdown_timer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .load         (load),
      .load_hours   (load_hours),
      .load_minutes (load_minutes),
      .load_seconds (load_seconds),
      .hours        (hours),
      .minutes      (minutes),
      .seconds      (seconds),
      .milliseconds (milliseconds),
      .running      (running),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Reference: remaining time as a single count of hundredths.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
   int m_total = 0;
   int m_st = M_IDLE;
   bit m_prev = 1'b0;
   bit m_valid = 1'b0;

   function automatic int clamp59(input int v);
      return (v > 59) ? 59 : v;
   endfunction

   always @(posedge clk) begin
      int  preset;
      bit  edge_s;
      if (reset) begin
         m_total = 0;
         m_st    = M_IDLE;
         m_prev  = 1'b0;
         m_valid = 1'b1;
      end else begin
         edge_s = start && !m_prev;
         m_prev = start;
         preset = int'(load_hours) * 360000 + clamp59(int'(load_minutes)) * 6000 +
                  clamp59(int'(load_seconds)) * 100;
         if (m_st == M_IDLE) begin
            if (load) m_total = preset;
            else if (edge_s && m_total != 0) m_st = M_RUN;
         end else if (m_st == M_RUN) begin
            if (edge_s) m_st = M_PAUSE;
            else begin
               m_total = m_total - 1;
               if (m_total == 0) m_st = M_EXP;
            end
         end else if (m_st == M_PAUSE) begin
            if (load) begin m_total = preset; m_st = M_IDLE; end
            else if (edge_s && m_total != 0) m_st = M_RUN;
         end else begin
            if (load) begin m_total = preset; m_st = M_IDLE; end
         end
      end
   end

   // Per-cycle comparison of every output against the reference.
   always @(negedge clk) begin
      int eh, em, es, ems, er, ed;
      if (m_valid) begin
         eh  = m_total / 360000;
         em  = (m_total / 6000) % 60;
         es  = (m_total / 100) % 60;
         ems = m_total % 100;
         er  = (m_st == M_RUN) ? 1 : 0;
         ed  = (m_st == M_EXP) ? 1 : 0;
         vectors++;
         if (int'(hours) != eh || int'(minutes) != em || int'(seconds) != es ||
             int'(milliseconds) != ems || int'(running) != er || int'(done) != ed) begin
            miscompares++;
            $display("FAIL model t=%0t got %0d:%0d:%0d.%0d run=%0d done=%0d expected %0d:%0d:%0d.%0d run=%0d done=%0d",
                     $time, hours, minutes, seconds, milliseconds, running, done,
                     eh, em, es, ems, er, ed);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int h, input int m, input int s,
                      input int ms, input int r, input int d);
      #1;
      vectors++;
      if (int'(hours) != h || int'(minutes) != m || int'(seconds) != s ||
          int'(milliseconds) != ms || int'(running) != r || int'(done) != d) begin
         miscompares++;
         $display("FAIL %s got %0d:%0d:%0d.%0d run=%0d done=%0d expected %0d:%0d:%0d.%0d run=%0d done=%0d",
                  name, hours, minutes, seconds, milliseconds, running, done,
                  h, m, s, ms, r, d);
      end
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load_hours   = 6'(h);
      load_minutes = 6'(m);
      load_seconds = 6'(s);
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      chk("reset", 0, 0, 0, 0, 0, 0);

      // Five-second run to expiry.
      do_load(0, 0, 5);
      chk("load5", 0, 0, 5, 0, 0, 0);
      pulse_start();
      chk("start_latency", 0, 0, 5, 0, 1, 0);
      cyc(499);
      chk("one_left", 0, 0, 0, 1, 1, 0);
      cyc(1);
      chk("expired", 0, 0, 0, 0, 0, 1);
      pulse_start();
      cyc(3);
      chk("expired_ignores_start", 0, 0, 0, 0, 0, 1);

      // Borrow chains.
      do_load(0, 1, 0);
      chk("load_clears_done", 0, 1, 0, 0, 0, 0);
      pulse_start();
      cyc(1);
      chk("borrow_min", 0, 0, 59, 99, 1, 0);
      pulse_start();
      do_load(1, 0, 0);
      pulse_start();
      cyc(1);
      chk("borrow_hour", 0, 59, 59, 99, 1, 0);

      // Pause and resume.
      do_load(0, 0, 10);
      chk("running_ignores_load", 0, 59, 59, 98, 1, 0);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      do_load(0, 0, 10);
      pulse_start();
      cyc(150);
      chk("run150", 0, 0, 8, 50, 1, 0);
      pulse_start();
      chk("paused", 0, 0, 8, 50, 0, 0);
      cyc(50);
      chk("pause_hold", 0, 0, 8, 50, 0, 0);
      pulse_start();
      cyc(849);
      chk("resume_849", 0, 0, 0, 1, 1, 0);
      cyc(1);
      chk("resume_done", 0, 0, 0, 0, 0, 1);

      // Clamping, and load ignored while running.
      do_load(2, 63, 60);
      chk("clamp", 2, 59, 59, 0, 0, 0);
      pulse_start();
      cyc(3);
      load_hours = 6'd7; load_minutes = 6'd7; load_seconds = 6'd7;
      load = 1'b1;
      cyc(5);
      load = 1'b0;
      chk("load_while_run", 2, 59, 58, 92, 1, 0);

      // Reset mid-count, zero-time start, held start.
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      do_load(0, 0, 5);
      pulse_start();
      cyc(173);
      chk("at_3_27", 0, 0, 3, 27, 1, 0);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("mid_reset", 0, 0, 0, 0, 0, 0);
      pulse_start();
      chk("zero_start", 0, 0, 0, 0, 0, 0);
      do_load(0, 0, 1);
      start = 1'b1;
      cyc(20);
      chk("held_start", 0, 0, 0, 81, 1, 0);
      start = 1'b0;

      // Load and start edge together in IDLE: load wins.
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      load_hours = 6'd0; load_minutes = 6'd0; load_seconds = 6'd3;
      load = 1'b1; start = 1'b1;
      cyc(1);
      load = 1'b0;
      cyc(2);
      chk("load_beats_start", 0, 0, 3, 0, 0, 0);
      start = 1'b0;

      // Randomized traffic, checked every cycle by the reference.
      for (int i = 0; i < 6000; i++) begin
         reset = ($urandom_range(0, 399) == 0);
         load  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 29) == 0) start = ~start;
         load_hours   = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         load_minutes = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         load_seconds = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(0, 2));
         cyc(1);
      end
      reset = 1'b0; load = 1'b0; start = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001: clk  input  1  system clock; one clk cycle = one hundredth of a second (100 cycles per second).
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: start  input  1  run/pause request; rising edge (0->1 between consecutive samples) is one request, so a level held high is one request.
REQ-004: load  input  1  level; when high in a loadable state, presets time from load_* inputs.
REQ-005: load_hours  input  6  preset hours, 0..63.
REQ-006: load_minutes  input  6  preset minutes, 0..59; values >59 clamp to 59.
REQ-007: load_seconds  input  6  preset seconds, 0..59; values >59 clamp to 59.
REQ-008: hours  output  6  remaining hours, registered.
REQ-009: minutes  output  6  remaining minutes, registered.
REQ-010: seconds  output  6  remaining seconds, registered.
REQ-011: milliseconds  output  7  remaining hundredths, 0..99, registered.
REQ-012: running  output  1  high exactly while state = RUNNING.
REQ-013: done  output  1  high exactly while state = EXPIRED.

Function
REQ-014: Four states SHALL exist: IDLE, RUNNING, PAUSED, EXPIRED; all outputs are registered, with no combinational path from inputs to outputs.
REQ-015: Start-edge detection SHALL use a registered copy of start; an edge is start=1 with the previous sample=0.
REQ-016: IDLE: load=1 -> time := {load_hours, clamped minutes, clamped seconds, 0}, stay IDLE; start edge with nonzero time -> RUNNING; start edge with all-zero time -> stay IDLE.
REQ-017: RUNNING: each cycle decrements time by one hundredth; start edge -> PAUSED, and no decrement occurs on that edge; load is ignored.
REQ-018: Decrement rule: ms>0 -> ms-1; else ms:=99 and borrow from seconds; seconds 0 -> 59 and borrow from minutes; minutes 0 -> 59 and borrow from hours; hours decrement by 1.
REQ-019: On the edge where the decrement produces 0:0:0.00, the timer SHALL enter EXPIRED; time holds at zero and never wraps below zero.
REQ-020: PAUSED: time holds; start edge -> RUNNING if time is nonzero; load=1 -> preset time and go to IDLE.
REQ-021: EXPIRED: time holds at zero; start edges are ignored; load=1 -> preset time, go to IDLE, done clears on that edge.
REQ-022: Latency: the state change occurs on the edge where the start edge is sampled; the first decrement occurs on the following edge.
REQ-023: If load=1 and a start edge coincide in IDLE/PAUSED/EXPIRED, load wins and the start edge is discarded; in RUNNING, start wins and load is ignored.

Reset
REQ-024: reset=1 SHALL force on the next edge: state IDLE, all time outputs 0, running=0, done=0, start-edge register 0; this takes priority over all other inputs in any state, including mid-count.
REQ-025: After reset, with all-zero time, a start edge SHALL leave the block in IDLE with done=0.

Verification
REQ-026: Reset, load 0:0:5, start pulse -> running=1; after 500 decrement cycles all outputs are 0, done=1, running=0.
REQ-027: Load 0:1:0, run 1 cycle -> 0:0:59.99; load 1:0:0, run 1 cycle -> 0:59:59.99 (borrow chain).
REQ-028: Load 0:0:10, run 150 cycles, start pulse -> PAUSED at 0:0:8.50 and holds for 50 cycles; start pulse -> resumes; done is asserted 850 cycles after resume.
REQ-029: Load with load_minutes=63, load_seconds=60 -> minutes=59, seconds=59; load asserted while RUNNING -> time unaffected.
REQ-030: Assert reset mid-run at 0:0:3.27 -> next edge all outputs 0, IDLE; start pulse with zero time -> no run; start held high 20 cycles after a load -> exactly one run request.
